// File: rtl/multdiv_alu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_alu_sequencer_pkg
// Description : Shared constants for the multiply/divide sequencer. Holds the
//               ALU opcode encodings, the sequencer state encoding and the
//               default iteration count.
// Revision    : 1.0  initial release
// ============================================================================
package multdiv_alu_sequencer_pkg;

    localparam int ITERATIONS_DEFAULT = 32;

    // Opcodes understood by the shared execute-stage ALU
    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
    localparam logic [4:0] ALU_AND = 5'b00010;
    localparam logic [4:0] ALU_OR  = 5'b00011;
    localparam logic [4:0] ALU_SLL = 5'b00100;
    localparam logic [4:0] ALU_SRA = 5'b00101;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        NEG_A = 3'd1,
        NEG_B = 3'd2,
        RUN   = 3'd3,
        FIXUP = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/multdiv_alu_sequencer_alu_carry_detect.sv
`default_nettype none
// ============================================================================
// Module      : alu_carry_detect
// Description : Recovers the unsigned carry (add) or borrow (subtract) of a
//               32-bit ALU operation from the operand and result MSBs, so the
//               sequencer can use an ALU that exposes no carry output.
// Ports       : i_x_msb  operand A bit 31
//               i_y_msb  operand B bit 31
//               i_r_msb  ALU result bit 31
//               i_sub    1 = subtract (report borrow), 0 = add (report carry)
//               o_carry  carry-out of the add, or borrow of the subtract
// Revision    : 1.0  initial release
// ============================================================================
module alu_carry_detect (
    input  logic i_x_msb,
    input  logic i_y_msb,
    input  logic i_r_msb,
    input  logic i_sub,
    output logic o_carry
);

    logic w_carry_add;
    logic w_borrow_sub;

    // Carry out of bit 31: both MSBs set, or one set and the sum MSB cleared
    assign w_carry_add  = (i_x_msb & i_y_msb) | ((i_x_msb | i_y_msb) & ~i_r_msb);
    // Borrow out of bit 31 for x - y
    assign w_borrow_sub = (~i_x_msb & i_y_msb) | ((~i_x_msb | i_y_msb) & i_r_msb);

    assign o_carry = i_sub ? w_borrow_sub : w_carry_add;

endmodule
`default_nettype wire

// File: rtl/multdiv_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_alu_sequencer
// Description : Multi-cycle signed 32-bit multiply / divide that borrows the
//               execute-stage ALU. Operands are made positive (NEG_A, NEG_B),
//               a radix-2 shift-add multiply or restoring divide runs for
//               ITERATIONS cycles (RUN), and the sign is re-applied (FIXUP).
// Ports       : clock, reset            clock, synchronous active-high reset
//               data_operandA/B         operands, sampled on the start edge
//               ctrl_MULT / ctrl_DIV    start strobes (MULT wins if both)
//               alu_operandA/B, alu_opcode, alu_shiftamt  ALU requests
//               alu_result              combinational ALU answer
//               data_result, data_exception, data_resultRDY, busy
// Revision    : 1.0  initial release
// ============================================================================
module multdiv_alu_sequencer
    import multdiv_alu_sequencer_pkg::*;
#(
    parameter int          ITERATIONS      = ITERATIONS_DEFAULT,
    parameter logic [31:0] DIV_ZERO_RESULT = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] alu_operandA,
    output logic [31:0] alu_operandB,
    output logic [4:0]  alu_opcode,
    output logic [4:0]  alu_shiftamt,
    input  logic [31:0] alu_result,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    localparam int CNT_W = $clog2(ITERATIONS + 1);
    localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(ITERATIONS - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [31:0]      r_a;        // A, then |A| (multiplicand)
    logic [31:0]      r_b;        // B, then |B| (divisor)
    logic [31:0]      r_hi;       // product HI / partial remainder
    logic [31:0]      r_lo;       // product LO / quotient
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic             r_sa;
    logic             r_sb;
    logic             r_div_exc;
    logic [31:0]      r_result;
    logic             r_exc;
    logic             r_rdy;

    logic             w_start;
    logic             w_carry;
    logic [31:0]      w_rprime;
    logic [31:0]      w_b_mag;
    logic             w_sum_c;
    logic [31:0]      w_sum_s;
    logic             w_neg;
    logic             w_mul_ovf;

    assign w_start  = ctrl_MULT | ctrl_DIV;
    assign w_rprime = {r_hi[30:0], r_lo[31]};
    assign w_b_mag  = r_sb ? alu_result : r_b;
    assign w_neg    = r_sa ^ r_sb;

    // Multiply step: add |A| only when the multiplier LSB is set
    assign w_sum_c  = r_lo[0] ? w_carry    : 1'b0;
    assign w_sum_s  = r_lo[0] ? alu_result : r_hi;

    // Product magnitude {r_hi, r_lo} must fit in signed 32 bits; a negative
    // result may reach exactly 2^31. A zero product keeps r_lo[31] clear.
    assign w_mul_ovf = (r_hi != 32'h0) ||
                       ((w_neg && (r_lo != 32'h0)) ? (r_lo[31] && (r_lo[30:0] != 31'h0))
                                                   : r_lo[31]);

    alu_carry_detect u_carry (
        .i_x_msb (r_is_div ? w_rprime[31] : r_hi[31]),
        .i_y_msb (r_is_div ? r_b[31]      : r_a[31]),
        .i_r_msb (alu_result[31]),
        .i_sub   (r_is_div),
        .o_carry (w_carry)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        alu_operandA = 32'h0;
        alu_operandB = 32'h0;
        alu_opcode   = ALU_ADD;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next_state = NEG_A;
                end
            end
            NEG_A: begin
                alu_operandB = r_a;
                alu_opcode   = ALU_SUB;
                w_next_state = NEG_B;
            end
            NEG_B: begin
                alu_operandB = r_b;
                alu_opcode   = ALU_SUB;
                w_next_state = RUN;
            end
            RUN: begin
                if (r_is_div) begin
                    alu_operandA = w_rprime;
                    alu_operandB = r_b;
                    alu_opcode   = ALU_SUB;
                end else begin
                    alu_operandA = r_hi;
                    alu_operandB = r_a;
                    alu_opcode   = ALU_ADD;
                end
                if (r_cnt == C_LAST_ITER) begin
                    w_next_state = FIXUP;
                end
            end
            FIXUP: begin
                alu_operandB = r_lo;
                alu_opcode   = ALU_SUB;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_a       <= 32'h0;
            r_b       <= 32'h0;
            r_hi      <= 32'h0;
            r_lo      <= 32'h0;
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_sa      <= 1'b0;
            r_sb      <= 1'b0;
            r_div_exc <= 1'b0;
            r_result  <= 32'h0;
            r_exc     <= 1'b0;
            r_rdy     <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_a       <= data_operandA;
                        r_b       <= data_operandB;
                        r_is_div  <= ~ctrl_MULT;
                        r_sa      <= data_operandA[31];
                        r_sb      <= data_operandB[31];
                        r_div_exc <= (data_operandB == 32'h0) ||
                                     ((data_operandA == 32'h80000000) &&
                                      (data_operandB == 32'hFFFFFFFF));
                    end
                end
                NEG_A: begin
                    if (r_sa) begin
                        r_a <= alu_result;
                    end
                end
                NEG_B: begin
                    r_b   <= w_b_mag;
                    r_hi  <= 32'h0;
                    r_lo  <= r_is_div ? r_a : w_b_mag;
                    r_cnt <= '0;
                end
                RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_div) begin
                        // No borrow means the shifted remainder covers |B|
                        if (!w_carry) begin
                            r_hi <= alu_result;
                            r_lo <= {r_lo[30:0], 1'b1};
                        end else begin
                            r_hi <= w_rprime;
                            r_lo <= {r_lo[30:0], 1'b0};
                        end
                    end else begin
                        r_hi <= {w_sum_c, w_sum_s[31:1]};
                        r_lo <= {w_sum_s[0], r_lo[31:1]};
                    end
                end
                FIXUP: begin
                    r_rdy <= 1'b1;
                    r_exc <= r_is_div ? r_div_exc : w_mul_ovf;
                    if (r_is_div && r_div_exc) begin
                        r_result <= DIV_ZERO_RESULT;
                    end else begin
                        // Low word of the signed result, wrapping on overflow
                        r_result <= w_neg ? alu_result : r_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_shiftamt   = 5'b00000;
    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;
    assign busy           = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_multdiv_alu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_multdiv_alu_sequencer
// Description : Scoreboard bench for multdiv_alu_sequencer with a behavioural
//               ALU and a signed-arithmetic reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_multdiv_alu_sequencer;
    import multdiv_alu_sequencer_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_operandA = 32'h0;
    logic [31:0] data_operandB = 32'h0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV  = 1'b0;
    logic [31:0] alu_operandA;
    logic [31:0] alu_operandB;
    logic [4:0]  alu_opcode;
    logic [4:0]  alu_shiftamt;
    logic [31:0] alu_result;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          start;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   bcnt     = 0;

    multdiv_alu_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .alu_operandA   (alu_operandA),
        .alu_operandB   (alu_operandB),
        .alu_opcode     (alu_opcode),
        .alu_shiftamt   (alu_shiftamt),
        .alu_result     (alu_result),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Behavioural shared ALU
    always_comb begin
        case (alu_opcode)
            ALU_ADD: alu_result = alu_operandA + alu_operandB;
            ALU_SUB: alu_result = alu_operandA - alu_operandB;
            default: alu_result = 32'h0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, req);
    endtask

    function automatic exp_t model(input logic m, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint p;
        e.start = 0;
        if (m) begin
            p     = longint'($signed(a)) * longint'($signed(b));
            e.exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
            e.res = p[31:0];
        end else if (b == 32'h0 || (a == 32'h80000000 && b == 32'hFFFFFFFF)) begin
            e.exc = 1'b1;
            e.res = 32'h0;
        end else begin
            e.exc = 1'b0;
            e.res = $signed(a) / $signed(b);
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] sp [5];
        logic [31:0] r;
        int          v;
        sp = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
        r  = $urandom;
        case ($urandom_range(0, 4))
            0: begin v = int'($urandom_range(0, 200)) - 100; return v; end
            1: return r;
            2: return {{16{r[15]}}, r[15:0]};
            3: return sp[$urandom_range(0, 4)];
            default: return {28'h0, r[3:0]};
        endcase
    endfunction

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset) q.delete();
    end

    // Monitor: compares each RDY pulse against the oldest expectation
    always @(negedge clock) begin : mon
        exp_t e;
        if (busy) begin
            bcnt++;
        end else begin
            if (data_resultRDY && !reset) begin
                if (q.size() == 0) begin
                    check("unexpected_rdy", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("result", data_result, e.res);
                    check("exception", {31'h0, data_exception}, {31'h0, e.exc});
                    check("rdy_latency", cyc - e.start, 32'd35);
                    check("busy_cycles", bcnt, 32'd35);
                end
            end
            bcnt = 0;
        end
    end

    // Issue one operation at a negedge with the DUT idle; return at its RDY.
    task automatic run_op(input logic m, input logic d, input logic [31:0] a,
                          input logic [31:0] b, input int glitch_at);
        exp_t e;
        int   k;
        e       = model(m, a, b);
        e.start = cyc + 1;
        q.push_back(e);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        k = 1;
        while (!data_resultRDY && k < 100) begin
            if (k == glitch_at) begin
                ctrl_DIV  = 1'b1;
                ctrl_MULT = 1'($urandom_range(0, 1));
            end else begin
                ctrl_DIV  = 1'b0;
                ctrl_MULT = 1'b0;
            end
            @(negedge clock);
            k++;
        end
        ctrl_DIV  = 1'b0;
        ctrl_MULT = 1'b0;
        if (!data_resultRDY) check("rdy_timeout", 32'd0, 32'd1);
    endtask

    initial begin : stim
        int          rdy_seen;
        logic        m;
        logic [31:0] a;
        logic [31:0] b;

        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_result", data_result, 32'h0);
        check("reset_exception", {31'h0, data_exception}, 32'h0);
        check("reset_rdy", {31'h0, data_resultRDY}, 32'h0);
        check("reset_busy", {31'h0, busy}, 32'h0);
        check("idle_alu_opcode", {27'h0, alu_opcode}, {27'h0, ALU_ADD});
        check("idle_alu_opA", alu_operandA, 32'h0);
        check("idle_alu_opB", alu_operandB, 32'h0);
        check("alu_shiftamt", {27'h0, alu_shiftamt}, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        // Directed cases
        run_op(1, 0, 32'd7, 32'hFFFFFFFA, 0);
        run_op(1, 0, 32'h00010000, 32'h00010000, 0);
        run_op(1, 0, 32'h80000000, 32'd1, 0);
        run_op(0, 1, 32'hFFFFFFF9, 32'd2, 0);
        run_op(0, 1, 32'd100, 32'd7, 0);
        run_op(0, 1, 32'd5, 32'd0, 0);
        run_op(0, 1, 32'h80000000, 32'hFFFFFFFF, 0);
        run_op(1, 0, 32'hFFFFFFF3, 32'd11, 5);
        run_op(1, 1, 32'd12, 32'hFFFFFFFD, 0);
        run_op(1, 0, 32'h80000000, 32'hFFFFFFFF, 0);
        run_op(1, 0, 32'h0, 32'h80000000, 0);

        // Abort a divide with reset on its tenth cycle
        q.push_back(model(0, 32'd1000, 32'd3));
        data_operandA = 32'd1000;
        data_operandB = 32'd3;
        ctrl_DIV      = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_rdy", {31'h0, data_resultRDY}, 32'h0);
        check("abort_result", data_result, 32'h0);
        check("abort_exception", {31'h0, data_exception}, 32'h0);
        rdy_seen = 0;
        repeat (50) begin
            @(negedge clock);
            if (data_resultRDY) rdy_seen++;
        end
        check("abort_no_rdy", rdy_seen, 32'd0);
        run_op(1, 0, 32'd3, 32'd3, 0);

        // Randomized operations, issued back to back
        for (int i = 0; i < 40; i++) begin
            m = 1'($urandom_range(0, 1));
            a = rand_operand();
            b = rand_operand();
            run_op(m, ~m, a, b, (i % 3 == 0) ? int'($urandom_range(1, 34)) : 0);
        end

        @(negedge clock);
        check("scoreboard_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
